dvi_tmds_encoder: RTL

Consumes the registered RGB565 pixel stream and DE from the test pattern generator, plus pixel-aligned hsync/vsync, and produces three 10-bit TMDS symbols per pixel clock for a DVI transmitter serializer. Each channel expands its component to 8 bits, applies transition minimisation, and applies DC balancing with a running disparity counter. During blanking, each channel emits control tokens.

---
 rtl/video_pkg.sv | 54 +++++
 rtl/tmds_channel_enc.sv | 83 ++++++++
 rtl/dvi_tmds_encoder.sv | 88 ++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types, TMDS control tokens and CRC constants for the DVI encoder.
// The CRC helper is only referenced when DVI_FRAME_CRC_EN is defined.
package video_pkg;

    typedef logic [9:0] tmds_sym_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam tmds_sym_t TMDS_CTRL_00 = 10'h354;
    localparam tmds_sym_t TMDS_CTRL_01 = 10'h0AB;
    localparam tmds_sym_t TMDS_CTRL_10 = 10'h154;
    localparam tmds_sym_t TMDS_CTRL_11 = 10'h2AB;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic tmds_sym_t ctrl_token(input logic [1:0] ctl);
        tmds_sym_t t;
        case (ctl)
            2'b00:   t = TMDS_CTRL_00;
            2'b01:   t = TMDS_CTRL_01;
            2'b10:   t = TMDS_CTRL_10;
            default: t = TMDS_CTRL_11;
        endcase
        return t;
    endfunction

    // 16 data bits folded in MSB first, non-reflected CCITT.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC16_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 registers the transition-minimised word,
// stage 2 applies DC balancing against the running disparity and registers the symbol.
module tmds_channel_enc
    import video_pkg::*;
(
    input  logic      pixel_clk,
    input  logic      rst_n,
    input  logic [7:0] data,
    input  logic      de,
    input  logic      c0,
    input  logic      c1,
    output tmds_sym_t sym
);

    logic [3:0] n1_d;
    logic       use_xnor;
    logic [8:0] q_m;

    always_comb begin
        n1_d     = popcount8(data);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
        q_m      = '0;
        q_m[0]   = data[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
        end
        q_m[8] = ~use_xnor;
    end

    logic [8:0] q_m_r;
    logic       de_r;
    logic [1:0] ctrl_r;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            q_m_r  <= '0;
            de_r   <= 1'b0;
            ctrl_r <= 2'b00;
        end else begin
            q_m_r  <= q_m;
            de_r   <= de;
            ctrl_r <= {c1, c0};
        end
    end

    logic [3:0]        n1_q;
    logic signed [5:0] diff;
    logic signed [5:0] cnt;
    logic signed [5:0] cnt_nxt;
    tmds_sym_t         sym_nxt;

    // diff = N1 - N0 = 2*N1 - 8 for the 8 data bits of q_m
    always_comb begin
        n1_q    = popcount8(q_m_r[7:0]);
        diff    = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
        sym_nxt = TMDS_CTRL_00;
        cnt_nxt = '0;
        if (!de_r) begin
            sym_nxt = ctrl_token(ctrl_r);
            cnt_nxt = '0;
        end else if ((cnt == 6'sd0) || (n1_q == 4'd4)) begin
            sym_nxt = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
            cnt_nxt = q_m_r[8] ? (cnt + diff) : (cnt - diff);
        end else if ((!cnt[5] && (n1_q > 4'd4)) || (cnt[5] && (n1_q < 4'd4))) begin
            sym_nxt = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            cnt_nxt = cnt + (q_m_r[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            sym_nxt = {1'b0, q_m_r[8], q_m_r[7:0]};
            cnt_nxt = cnt + diff - (q_m_r[8] ? 6'sd0 : 6'sd2);
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sym <= TMDS_CTRL_00;
            cnt <= '0;
        end else begin
            sym <= sym_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// RGB565 to three-channel TMDS encoder with 2-cycle latency.
// Optional frame CRC over active pixels is built only when DVI_FRAME_CRC_EN is defined.
module dvi_tmds_encoder
    import video_pkg::*;
(
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  rgb565_t     rgb565_in,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;

    assign r8 = {rgb565_in.r, rgb565_in.r[4:2]};
    assign g8 = {rgb565_in.g, rgb565_in.g[5:4]};
    assign b8 = {rgb565_in.b, rgb565_in.b[4:2]};

    tmds_channel_enc u_ch0 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .data      (b8),
        .de        (de_in),
        .c0        (hsync_in),
        .c1        (vsync_in),
        .sym       (tmds_ch0)
    );

    tmds_channel_enc u_ch1 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .data      (g8),
        .de        (de_in),
        .c0        (1'b0),
        .c1        (1'b0),
        .sym       (tmds_ch1)
    );

    tmds_channel_enc u_ch2 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .data      (r8),
        .de        (de_in),
        .c0        (1'b0),
        .c1        (1'b0),
        .sym       (tmds_ch2)
    );

`ifdef DVI_FRAME_CRC_EN
    logic        vsync_d;
    logic [15:0] crc_acc;
    logic [15:0] crc_upd;

    assign crc_upd = crc16_next(crc_acc, rgb565_in);

    // A pixel coinciding with the vsync edge belongs to the frame being closed.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            crc_acc   <= CRC16_INIT;
            frame_crc <= 16'h0000;
            crc_valid <= 1'b0;
        end else begin
            vsync_d   <= vsync_in;
            crc_valid <= 1'b0;
            if (vsync_in && !vsync_d) begin
                frame_crc <= de_in ? crc_upd : crc_acc;
                crc_valid <= 1'b1;
                crc_acc   <= CRC16_INIT;
            end else if (de_in) begin
                crc_acc <= crc_upd;
            end
        end
    end
`else
    assign frame_crc = 16'h0000;
    assign crc_valid = 1'b0;
`endif

endmodule
